// File: rtl/fpu_ret_queue.sv
// In-order retire queue merging the u1/u3/u5 FPU completion ports and draining one entry per cycle.
// Optional sticky IEEE exception flag accumulator enabled by defining FPU_RETQ_XFLAGS_EN.
module fpu_ret_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_MARGIN = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [13:0]                u1_ret,
  input  logic                       u1_ret_en,
  input  logic [13:0]                u3_ret,
  input  logic                       u3_ret_en,
  input  logic [13:0]                u5_ret,
  input  logic                       u5_ret_en,
  output logic                       rq_valid,
  input  logic                       rq_ready,
  output logic [13:0]                rq_data,
  output logic [1:0]                 rq_port,
  output logic [$clog2(DEPTH):0]     rq_count,
  output logic                       rq_hold,
  output logic                       rq_ovf
`ifdef FPU_RETQ_XFLAGS_EN
  ,
  input  logic                       fpxflags_clr,
  output logic [5:0]                 fpxflags
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [13:0]   data_q, data_d;
  logic [1:0]    port_q, port_d;
  logic          hold_q, hold_d;
  logic          ovf_q, ovf_d;

  logic [13:0]   ret_w [3];
  logic [2:0]    ret_en;
  logic [CW-1:0] space;
  logic [CW-1:0] acc;
  logic [AW-1:0] slot;
  logic          drop;
  logic          pop;
  logic [15:0]   head;

`ifdef FPU_RETQ_XFLAGS_EN
  logic [2:0]    acc_mask;
  logic [5:0]    flags_q, flags_d;
`endif

  assign ret_w[0] = u1_ret;
  assign ret_w[1] = u3_ret;
  assign ret_w[2] = u5_ret;
  assign ret_en   = {u5_ret_en, u3_ret_en, u1_ret_en};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;
    port_d   = port_q;
    ovf_d    = ovf_q;
    acc      = '0;
    drop     = 1'b0;
    slot     = '0;
    head     = '0;
`ifdef FPU_RETQ_XFLAGS_EN
    acc_mask = '0;
`endif
    // Space is judged on the start-of-cycle count; a same-cycle pop frees nothing.
    space    = CW'(DEPTH) - count_q;
    pop      = valid_q & rq_ready;

    for (int unsigned p = 0; p < 3; p++) begin
      if (ret_en[p]) begin
        if (acc < space) begin
          slot        = wr_ptr_q + acc[AW-1:0];
          mem_d[slot] = {2'(p), ret_w[p]};
          acc         = acc + 1'b1;
`ifdef FPU_RETQ_XFLAGS_EN
          acc_mask[p] = 1'b1;
`endif
        end else begin
          drop = 1'b1;
        end
      end
    end

    if (flush) begin
      mem_d    = mem_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
`ifdef FPU_RETQ_XFLAGS_EN
      acc_mask = '0;
`endif
    end else begin
      wr_ptr_d = wr_ptr_q + acc[AW-1:0];
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + acc - CW'(pop);
      ovf_d    = ovf_q | drop;
      valid_d  = (count_d != '0);
      // Head is read from the post-write image so a push into an empty queue shows next cycle.
      if (valid_d) begin
        head   = mem_d[rd_ptr_d];
        port_d = head[15:14];
        data_d = head[13:0];
      end
    end

    hold_d = (CW'(DEPTH) - count_d) < CW'(HOLD_MARGIN);
  end

`ifdef FPU_RETQ_XFLAGS_EN
  always_comb begin
    flags_d = flags_q;
    for (int unsigned p = 0; p < 3; p++) begin
      if (acc_mask[p]) flags_d = flags_d | ret_w[p][5:0];
    end
    if (fpxflags_clr) flags_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign fpxflags = flags_q;
`endif

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      port_q   <= '0;
      hold_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      port_q   <= port_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rq_valid = valid_q;
  assign rq_data  = data_q;
  assign rq_port  = port_q;
  assign rq_count = count_q;
  assign rq_hold  = hold_q;
  assign rq_ovf   = ovf_q;

endmodule

// File: tb/tb_fpu_ret_queue.sv
// Self-checking bench for fpu_ret_queue: directed table, hand sequences and random traffic vs a queue model.
// Exercises the flag accumulator when FPU_RETQ_XFLAGS_EN is defined.
module tb_fpu_ret_queue;

  localparam int DEPTH = 16;
  localparam int HOLD_MARGIN = 9;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic        rq_valid, rq_ready;
  logic [13:0] rq_data;
  logic [1:0]  rq_port;
  logic [4:0]  rq_count;
  logic        rq_hold, rq_ovf;
`ifdef FPU_RETQ_XFLAGS_EN
  logic        fpxflags_clr;
  logic [5:0]  fpxflags;
  logic [5:0]  m_flags;
`endif

  always #5 clk = ~clk;

  fpu_ret_queue #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
    .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
    .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_data(rq_data), .rq_port(rq_port),
    .rq_count(rq_count), .rq_hold(rq_hold), .rq_ovf(rq_ovf)
`ifdef FPU_RETQ_XFLAGS_EN
    ,
    .fpxflags_clr(fpxflags_clr), .fpxflags(fpxflags)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: an ordered list of {port, word}, plus sticky/held state.
  logic [15:0] mq[$];
  logic        m_ovf;
  logic [15:0] m_last;

  typedef struct {
    logic        fl;
    logic [2:0]  en;
    logic [13:0] a, b, c;
    logic        rdy;
    int          cnt;
    logic        vld;
    logic [13:0] data;
    logic [1:0]  port;
    logic        hold;
    logic        ovf;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic fl, logic [2:0] en, logic [13:0] a, logic [13:0] b,
                              logic [13:0] c, logic rdy, int cnt, logic vld,
                              logic [13:0] data, logic [1:0] port, logic hold, logic ovf);
    vec_t v;
    v.fl = fl; v.en = en; v.a = a; v.b = b; v.c = c; v.rdy = rdy;
    v.cnt = cnt; v.vld = vld; v.data = data; v.port = port; v.hold = hold; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_update(input logic r, input logic fl, input logic [2:0] en,
                              input logic [13:0] a, input logic [13:0] b, input logic [13:0] c,
                              input logic rdy, input logic clr);
    logic [13:0] w [3];
    int          free;
    logic        do_pop;
    w[0] = a; w[1] = b; w[2] = c;
    if (r) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = '0;
`ifdef FPU_RETQ_XFLAGS_EN
      m_flags = '0;
`endif
      return;
    end
    if (fl) begin
      mq.delete();
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      free   = DEPTH - mq.size();
      for (int p = 0; p < 3; p++) begin
        if (en[p]) begin
          if (free > 0) begin
            mq.push_back({2'(p), w[p]});
            free--;
`ifdef FPU_RETQ_XFLAGS_EN
            m_flags = m_flags | w[p][5:0];
`endif
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (do_pop) void'(mq.pop_front());
    end
`ifdef FPU_RETQ_XFLAGS_EN
    if (clr) m_flags = '0;
`else
    if (clr) m_last = m_last;
`endif
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic step(input logic r, input logic fl, input logic [2:0] en,
                      input logic [13:0] a, input logic [13:0] b, input logic [13:0] c,
                      input logic rdy, input logic clr);
    rst = r; flush = fl;
    u1_ret_en = en[0]; u3_ret_en = en[1]; u5_ret_en = en[2];
    u1_ret = a; u3_ret = b; u5_ret = c;
    rq_ready = rdy;
`ifdef FPU_RETQ_XFLAGS_EN
    fpxflags_clr = clr;
`endif
    @(posedge clk);
    model_update(r, fl, en, a, b, c, rdy, clr);
    #1;
    chk("m_valid", 32'(rq_valid), 32'(mq.size() > 0));
    chk("m_data",  32'(rq_data),  32'(m_last[13:0]));
    chk("m_port",  32'(rq_port),  32'(m_last[15:14]));
    chk("m_count", 32'(rq_count), 32'(mq.size()));
    chk("m_hold",  32'(rq_hold),  32'((DEPTH - mq.size()) < HOLD_MARGIN));
    chk("m_ovf",   32'(rq_ovf),   32'(m_ovf));
`ifdef FPU_RETQ_XFLAGS_EN
    chk("m_flags", 32'(fpxflags), 32'(m_flags));
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rq_ready = 1'b0;
    u1_ret = '0; u3_ret = '0; u5_ret = '0;
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
`ifdef FPU_RETQ_XFLAGS_EN
    fpxflags_clr = 1'b0;
    m_flags = '0;
`endif
    m_ovf = 1'b0; m_last = '0;

    tbl[0]  = mk(0, 3'b001, 14'h0123, 0, 0, 1, 1, 1, 14'h0123, 0, 0, 0);
    tbl[1]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 14'h0123, 0, 0, 0);
    tbl[2]  = mk(0, 3'b111, 14'h0001, 14'h0002, 14'h0003, 0, 3, 1, 14'h0001, 0, 0, 0);
    tbl[3]  = mk(0, 3'b000, 0, 0, 0, 1, 2, 1, 14'h0002, 1, 0, 0);
    tbl[4]  = mk(0, 3'b000, 0, 0, 0, 1, 1, 1, 14'h0003, 2, 0, 0);
    tbl[5]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 14'h0003, 2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tbl[6+k] = mk(0, 3'b111, 14'h0A0 + 14'(k), 14'h0B0 + 14'(k), 14'h0C0 + 14'(k), 0,
                    (k < 5) ? 3*(k+1) : 16, 1, 14'h00A0, 0, (k >= 2), (k == 5));
    end
    tbl[12] = mk(0, 3'b000, 0, 0, 0, 1, 15, 1, 14'h00B0, 1, 1, 1);
    tbl[13] = mk(0, 3'b011, 14'h00D1, 14'h00D2, 0, 1, 15, 1, 14'h00C0, 2, 1, 1);
    tbl[14] = mk(1, 3'b100, 0, 0, 14'h00E5, 0, 0, 0, 14'h00C0, 2, 0, 1);

    // Reset held two cycles; outputs must be cleared.
    step(1, 0, 3'b000, 0, 0, 0, 0, 0);
    step(1, 0, 3'b000, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(rq_valid), 0);
    chk("rst_count", 32'(rq_count), 0);
    chk("rst_data",  32'(rq_data),  0);

    for (int i = 0; i < 15; i++) begin
      step(0, tbl[i].fl, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].rdy, 0);
      chk($sformatf("t%0d_count", i), 32'(rq_count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_valid", i), 32'(rq_valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_data", i),  32'(rq_data),  32'(tbl[i].data));
      chk($sformatf("t%0d_port", i),  32'(rq_port),  32'(tbl[i].port));
      chk($sformatf("t%0d_hold", i),  32'(rq_hold),  32'(tbl[i].hold));
      chk($sformatf("t%0d_ovf", i),   32'(rq_ovf),   32'(tbl[i].ovf));
    end

    // Reset clears the sticky overflow; then fill to 5 and flush with a u5 push.
    step(1, 0, 3'b000, 0, 0, 0, 0, 0);
    chk("rst_ovf", 32'(rq_ovf), 0);
    step(0, 0, 3'b111, 14'h0011, 14'h0012, 14'h0013, 0, 0);
    step(0, 0, 3'b011, 14'h0014, 14'h0015, 0, 0, 0);
    chk("f5_count", 32'(rq_count), 5);
    step(0, 1, 3'b100, 0, 0, 14'h0016, 1, 0);
    chk("fl_count", 32'(rq_count), 0);
    chk("fl_valid", 32'(rq_valid), 0);
    // Ready while empty must not pop anything.
    step(0, 0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 0, 3'b001, 14'h0021, 0, 0, 1, 0);
    chk("emp_count", 32'(rq_count), 1);

`ifdef FPU_RETQ_XFLAGS_EN
    step(1, 0, 3'b000, 0, 0, 0, 0, 0);
    step(0, 0, 3'b001, 14'h0201, 0, 0, 1, 0);
    step(0, 0, 3'b010, 0, 14'h0310, 0, 1, 0);
    chk("xf_or", 32'(fpxflags), 32'h11);
    step(0, 0, 3'b000, 0, 0, 0, 1, 1);
    chk("xf_clr", 32'(fpxflags), 0);
`endif

    // Random traffic: a low-ready phase reaches full/overflow, a high-ready phase drains.
    for (int i = 0; i < 500; i++) begin
      logic [2:0] en;
      logic       rdy, fl, clr;
      en  = 3'($urandom);
      rdy = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step((i == 300), fl, en, 14'($urandom), 14'($urandom), 14'($urandom), rdy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
